mult_limb_seq: RTL and testbench

MULT_LIMB_SEQ -- requirements
Module: mult_limb_seq

---
 rtl/mult_limb_pkg.sv | 15 +
 rtl/mult_limb_seq_if.sv | 30 +++
 rtl/limb_pp_lane.sv | 27 ++
 rtl/mult_limb_seq.sv | 143 ++++++++++++++
 tb/tb_mult_limb_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_limb_pkg.sv
// Shared definitions for the sequential limb multiplier: FSM encoding and
// the ceil-division helper used to size limb counts and cycle counts.
package mult_limb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/mult_limb_seq_if.sv
// Operand/result handshake bundle for mult_limb_seq. The master drives
// operands and out_ready; the slave (the multiplier) returns the product.
interface mult_limb_seq_if #(
  parameter int unsigned A_BITS = 130,
  parameter int unsigned B_BITS = 128
);
  localparam int unsigned P_BITS = A_BITS + B_BITS;

  logic              in_valid;
  logic              in_ready;
  logic              mode;
  logic [A_BITS-1:0] a_in;
  logic [B_BITS-1:0] b_in;
  logic [P_BITS-1:0] c_in;
  logic              out_valid;
  logic              out_ready;
  logic [P_BITS-1:0] product_out;
  logic              busy;

  modport master (
    output in_valid, mode, a_in, b_in, c_in, out_ready,
    input  in_ready, out_valid, product_out, busy
  );

  modport slave (
    input  in_valid, mode, a_in, b_in, c_in, out_ready,
    output in_ready, out_valid, product_out, busy
  );

endinterface

// File: rtl/limb_pp_lane.sv
// One partial-product lane: limb x limb, placed at its limb offset inside
// the full-width accumulator. A disabled lane contributes zero.
module limb_pp_lane #(
  parameter int unsigned LIMB   = 16,
  parameter int unsigned P_BITS = 258,
  parameter int unsigned SH_W   = 5
) (
  input  logic [LIMB-1:0]   i_a_limb,
  input  logic [LIMB-1:0]   i_b_limb,
  input  logic [SH_W-1:0]   i_shift,
  input  logic              i_en,
  output logic [P_BITS-1:0] o_pp
);

  localparam int unsigned PW = 2 * LIMB;

  logic [PW-1:0]     w_prod;
  logic [P_BITS-1:0] w_ext;
  logic [31:0]       w_shamt;

  assign w_prod  = PW'(i_a_limb) * PW'(i_b_limb);
  assign w_ext   = P_BITS'(w_prod);
  assign w_shamt = 32'(i_shift) * LIMB;
  // Bits shifted past P_BITS fall off, which gives the modulo-2^P_BITS sum.
  assign o_pp    = i_en ? (w_ext << w_shamt) : '0;

endmodule

// File: rtl/mult_limb_seq.sv
// Sequential multiply / multiply-add: splits operands into limbs and sums
// PAR shifted limb products per cycle into a full-width accumulator.
module mult_limb_seq
  import mult_limb_pkg::*;
#(
  parameter int unsigned LIMB   = 16,
  parameter int unsigned A_BITS = 130,
  parameter int unsigned B_BITS = 128,
  parameter int unsigned PAR    = 4
) (
  input logic            clk,
  input logic            reset,
  mult_limb_seq_if.slave bus
);

  localparam int unsigned P_BITS  = A_BITS + B_BITS;
  localparam int unsigned A_LIMBS = ceil_div(A_BITS, LIMB);
  localparam int unsigned B_LIMBS = ceil_div(B_BITS, LIMB);
  localparam int unsigned TOTAL   = A_LIMBS * B_LIMBS;
  localparam int unsigned K       = ceil_div(TOTAL, PAR);
  localparam int unsigned A_EXT   = A_LIMBS * LIMB;
  localparam int unsigned B_EXT   = B_LIMBS * LIMB;
  // r_idx steps by PAR up to K*PAR on the final RUN edge.
  localparam int unsigned IDX_W   = $clog2(K * PAR + 1);
  localparam int unsigned AI_W    = (A_LIMBS > 1) ? $clog2(A_LIMBS) : 1;
  localparam int unsigned BI_W    = (B_LIMBS > 1) ? $clog2(B_LIMBS) : 1;
  localparam int unsigned SH_W    = $clog2(A_LIMBS + B_LIMBS);

  state_e            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [LIMB-1:0]   r_a_limbs [A_LIMBS];
  logic [LIMB-1:0]   r_b_limbs [B_LIMBS];
  logic [P_BITS-1:0] r_acc;
  logic [P_BITS-1:0] r_product;
  logic [IDX_W-1:0]  r_idx;

  logic [A_EXT-1:0]  w_a_ext;
  logic [B_EXT-1:0]  w_b_ext;
  logic [P_BITS-1:0] w_pp [PAR];
  logic [P_BITS-1:0] w_sum;

  assign w_a_ext = A_EXT'(bus.a_in);
  assign w_b_ext = B_EXT'(bus.b_in);

  for (genvar p = 0; p < PAR; p++) begin : g_lane
    logic [IDX_W-1:0] w_j;
    logic             w_en;
    logic [AI_W-1:0]  w_ai;
    logic [BI_W-1:0]  w_bj;
    logic [SH_W-1:0]  w_sh;

    always_comb begin
      w_j  = r_idx + IDX_W'(p);
      w_en = (r_state == StRun) && (32'(w_j) < TOTAL);
      w_ai = '0;
      w_bj = '0;
      if (w_en) begin
        w_ai = AI_W'(32'(w_j) / B_LIMBS);
        w_bj = BI_W'(32'(w_j) % B_LIMBS);
      end
      w_sh = SH_W'(w_ai) + SH_W'(w_bj);
    end

    limb_pp_lane #(
      .LIMB   (LIMB),
      .P_BITS (P_BITS),
      .SH_W   (SH_W)
    ) u_lane (
      .i_a_limb (r_a_limbs[w_ai]),
      .i_b_limb (r_b_limbs[w_bj]),
      .i_shift  (w_sh),
      .i_en     (w_en),
      .o_pp     (w_pp[p])
    );
  end

  always_comb begin
    w_sum = r_acc;
    for (int p = 0; p < PAR; p++) begin
      w_sum = w_sum + w_pp[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_acc       <= '0;
      r_product   <= '0;
      r_idx       <= '0;
      for (int i = 0; i < A_LIMBS; i++) r_a_limbs[i] <= '0;
      for (int i = 0; i < B_LIMBS; i++) r_b_limbs[i] <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            for (int i = 0; i < A_LIMBS; i++) r_a_limbs[i] <= w_a_ext[i*LIMB +: LIMB];
            for (int i = 0; i < B_LIMBS; i++) r_b_limbs[i] <= w_b_ext[i*LIMB +: LIMB];
            r_acc      <= bus.mode ? bus.c_in : '0;
            r_idx      <= '0;
            r_state    <= StRun;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        StRun: begin
          r_acc <= w_sum;
          r_idx <= r_idx + IDX_W'(PAR);
          if (32'(r_idx) + PAR >= TOTAL) begin
            r_product   <= w_sum;
            r_state     <= StDone;
            r_out_valid <= 1'b1;
          end
        end
        StDone: begin
          // Returning to idle here means new operands are taken one edge later.
          if (bus.out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.busy        = r_busy;
  assign bus.product_out = r_product;

endmodule

// File: tb/tb_mult_limb_seq.sv
// Bench for mult_limb_seq: three configurations driven in lockstep and
// checked against a plain-arithmetic model of a*b (+c) modulo 2^258.
module tb_mult_limb_seq;

  localparam int unsigned AB = 130;
  localparam int unsigned BB = 128;
  localparam int unsigned PB = AB + BB;
  // Edges counted from the acceptance edge (inclusive) to out_valid.
  localparam int LAT4  = 19;
  localparam int LAT5  = 16;
  localparam int LAT32 = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_limb_seq_if #(.A_BITS(AB), .B_BITS(BB)) if0 ();
  mult_limb_seq_if #(.A_BITS(AB), .B_BITS(BB)) if5 ();
  mult_limb_seq_if #(.A_BITS(AB), .B_BITS(BB)) if32 ();

  mult_limb_seq #(.LIMB(16), .A_BITS(AB), .B_BITS(BB), .PAR(4)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );
  mult_limb_seq #(.LIMB(16), .A_BITS(AB), .B_BITS(BB), .PAR(5)) u_dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (if5.slave)
  );
  mult_limb_seq #(.LIMB(32), .A_BITS(AB), .B_BITS(BB), .PAR(4)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (if32.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [PB-1:0] got0, got5, got32;
  int lat0, lat5, lat32;

  task automatic check(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [PB-1:0] model(input logic m, input logic [AB-1:0] a,
                                          input logic [BB-1:0] b, input logic [PB-1:0] c);
    logic [PB-1:0] p;
    p = PB'(a) * PB'(b);
    if (m) p = p + c;
    return p;
  endfunction

  function automatic logic [AB-1:0] rnd_a();
    logic [159:0] t;
    logic [AB-1:0] r;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    r = t[AB-1:0];
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [BB-1:0] rnd_b();
    logic [BB-1:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [PB-1:0] rnd_c();
    logic [287:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return t[PB-1:0];
  endfunction

  task automatic drive(input logic v, input logic m, input logic [AB-1:0] a,
                       input logic [BB-1:0] b, input logic [PB-1:0] c);
    if0.in_valid  = v; if0.mode  = m; if0.a_in  = a; if0.b_in  = b; if0.c_in  = c;
    if5.in_valid  = v; if5.mode  = m; if5.a_in  = a; if5.b_in  = b; if5.c_in  = c;
    if32.in_valid = v; if32.mode = m; if32.a_in = a; if32.b_in = b; if32.c_in = c;
  endtask

  task automatic set_ready(input logic r);
    if0.out_ready  = r;
    if5.out_ready  = r;
    if32.out_ready = r;
  endtask

  // One transaction on all three instances; junk operands stay valid while busy.
  task automatic do_op(input logic m, input logic [AB-1:0] a, input logic [BB-1:0] b,
                       input logic [PB-1:0] c, input int stall);
    logic [PB-1:0] exp;
    exp  = model(m, a, b, c);
    lat0 = 0; lat5 = 0; lat32 = 0;
    got0 = '0; got5 = '0; got32 = '0;
    drive(1'b1, m, a, b, c);
    @(posedge clk); #1;
    drive(1'b1, 1'($urandom()), rnd_a(), rnd_b(), rnd_c());
    for (int e = 1; e <= 40; e++) begin
      if (lat0 == 0 && if0.out_valid === 1'b1) begin lat0 = e; got0 = if0.product_out; end
      if (lat5 == 0 && if5.out_valid === 1'b1) begin lat5 = e; got5 = if5.product_out; end
      if (lat32 == 0 && if32.out_valid === 1'b1) begin lat32 = e; got32 = if32.product_out; end
      if (lat0 != 0 && lat5 != 0 && lat32 != 0) break;
      @(posedge clk); #1;
    end
    check_int("lat_par4", lat0, LAT4);
    check_int("lat_par5", lat5, LAT5);
    check_int("lat_limb32", lat32, LAT32);
    check("prod_par4", got0, exp);
    check("prod_par5", got5, exp);
    check("prod_limb32", got32, exp);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("hold_prod", if0.product_out, got0);
      check_int("hold_in_ready", 32'(if0.in_ready), 0);
      check_int("hold_out_valid", 32'(if0.out_valid), 1);
    end
    set_ready(1'b1);
    @(posedge clk); #1;
    check_int("handoff_in_ready", 32'(if0.in_ready), 1);
    check_int("handoff_busy", 32'(if0.busy), 0);
    check_int("handoff_busy_par5", 32'(if5.busy), 0);
    drive(1'b0, 1'b0, '0, '0, '0);
    set_ready(1'b0);
  endtask

  initial begin
    logic [PB-1:0] e_max, two256;
    logic [AB-1:0] pa;
    logic [BB-1:0] pb;
    int stale;

    drive(1'b0, 1'b0, '0, '0, '0);
    set_ready(1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_in_ready", 32'(if0.in_ready), 1);
    check_int("rst_out_valid", 32'(if0.out_valid), 0);
    check_int("rst_busy", 32'(if0.busy), 0);
    check("rst_prod", if0.product_out, '0);
    reset = 1'b0;

    // All-ones operands: (2^130-1)(2^128-1) = 2^258 - 2^130 - 2^128 + 1.
    e_max = PB'(1) - (PB'(1) << 130) - (PB'(1) << 128);
    do_op(1'b0, '1, '1, '0, 0);
    check("max_prod_const", got0, e_max);

    do_op(1'b1, AB'(3), BB'(5), PB'(7), 0);
    check("madd_22", got0, PB'(22));

    do_op(1'b1, '0, rnd_b(), '0, 0);
    check("zero_prod", got0, '0);

    // 2^129 * 2^127 with out_ready withheld for 10 cycles.
    pa = '0; pa[129] = 1'b1;
    pb = '0; pb[127] = 1'b1;
    two256 = '0; two256[256] = 1'b1;
    do_op(1'b0, pa, pb, '0, 10);
    check("pow2_limb32", got32, two256);

    // Reset in the fifth RUN cycle discards the in-flight result.
    drive(1'b1, 1'b0, '1, '1, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_int("midrst_in_ready", 32'(if0.in_ready), 1);
    check_int("midrst_out_valid", 32'(if0.out_valid), 0);
    check("midrst_prod", if0.product_out, '0);
    reset = 1'b0;
    stale = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (if0.out_valid !== 1'b0 || if5.out_valid !== 1'b0 || if32.out_valid !== 1'b0) stale++;
    end
    check_int("no_stale_result", stale, 0);

    for (int n = 0; n < 1000; n++) begin
      do_op(1'($urandom_range(0, 1)), rnd_a(), rnd_b(), rnd_c(), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
